counter_ud_mode: RTL
====================

Name: counter_ud_mode

Overview:
Parametrised up/down counter with enable. It generalises the fixed 8-bit enable counter with:
- configurable width and modulus (MAX_VAL),
- runtime direction and step size,
- synchronous load,
- three overflow modes: wrap, saturate, one-shot,
- terminal-count pulse and sticky overflow flag.

It is used as a timer, prescaler and event counter in peripheral blocks, and is the reusable counter primitive for the sva_tests suite.

Parameters:
WIDTH, 8, counter/step/load width in bits
MAX_VAL, 2**WIDTH-1, top of count range; counter spans 0..MAX_VAL
RST_VAL, 0, value of cnt after reset
MODE, CNT_WRAP, overflow mode from counter_pkg::cnt_mode_t: CNT_WRAP, CNT_SAT, CNT_ONESHOT

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
en  in  1  count enable, one step per cycle while high
dir  in  1  1 = count up, 0 = count down
step  in  WIDTH  increment/decrement amount
load  in  1  synchronous load strobe
load_val  in  WIDTH  value for load
start  in  1  ONESHOT arm/restart strobe; ignored in other modes
cnt  out  WIDTH  current count, registered
tc  out  1  terminal-count pulse, registered, aligned with the cnt value that caused it
ovf  out  1  sticky overflow/underflow flag
busy  out  1  counter is in RUN state

Behaviour:
- Single clock, synchronous active-high reset. All outputs are registered. A change of cnt is visible in the cycle after its inputs are sampled.
- Priority per edge: rst > load > start > en.
- Reset: cnt=RST_VAL, tc=0, ovf=0. FSM goes to RUN for WRAP/SAT, to IDLE for ONESHOT. Reset mid-count overrides everything.
- Step clamp: eff_step = min(step, MAX_VAL). step=0 leaves cnt unchanged, no tc, no ovf.
- Arithmetic uses a WIDTH+1-bit raw result, computed combinationally.
  - Up: raw = cnt+eff_step; out of range if raw > MAX_VAL.
  - Down: out of range if eff_step > cnt.
- Out-of-range result by mode:
  - WRAP up: cnt = raw-(MAX_VAL+1).
  - WRAP down: cnt = cnt+MAX_VAL+1-eff_step.
  - SAT and ONESHOT: clamp to MAX_VAL (up) or 0 (down).
- ovf: set on any enabled counting step whose raw result is out of range, including en while already saturated. Cleared only by rst, load, or start (ONESHOT).
- tc:
  - WRAP: 1 for one cycle when a wrap occurs.
  - SAT/ONESHOT: 1 for one cycle when cnt moves onto the boundary (MAX_VAL up / 0 down) from a non-boundary value.
  - Holding at the boundary gives no further tc.
  - tc=0 on cycles with load, start or rst.
- load: cnt = min(load_val, MAX_VAL); ovf cleared; FSM state unchanged; no tc.
- FSM states IDLE, RUN, DONE:
  - WRAP/SAT: permanently RUN; busy=1 after reset.
  - ONESHOT IDLE: en ignored, busy=0. start loads cnt = 0 (dir=1) or MAX_VAL (dir=0), clears ovf, goes to RUN.
  - ONESHOT RUN: counts on en; reaching the boundary goes to DONE with tc pulse.
  - ONESHOT DONE: cnt held, en ignored, busy=0. start re-arms as from IDLE.
  - start while in RUN restarts the count (same reload) and stays in RUN.
- Direction change mid-count is legal and takes effect on the same edge.
- Elaboration checks: MAX_VAL <= 2**WIDTH-1, RST_VAL <= MAX_VAL, WIDTH >= 1. Violation is a $fatal.

Decomposition:
- counter_pkg:
  - cnt_mode_t enum (CNT_WRAP, CNT_SAT, CNT_ONESHOT)
  - cnt_state_t enum (IDLE, RUN, DONE)
- Sub-module counter_next_calc: purely combinational.
  - Inputs: cnt, eff_step, dir, MODE, MAX_VAL.
  - Outputs: next value, out_of_range, hit_boundary.
- The top holds the FSM, priority mux and output registers.

Test Plan:
1. WRAP, MAX_VAL=9, up, step=1, en=1 from reset -> cnt 0..9 then 0; tc=1 only on the cycle cnt=0 appears; ovf=1 from then on.
2. SAT, load_val=7 then down, step=3, en=1 -> cnt 4,1,0,0; tc=1 once with cnt=0; ovf set on the 1->0 step and held.
3. ONESHOT, MAX_VAL=9, step=2, up:
   - en=1 in IDLE -> cnt stays RST_VAL, busy=0.
   - start -> cnt=0, busy=1; then 2,4,6,8,9 (clamped, tc=1, ovf=1, busy=0).
   - Further en -> no change.
   - start -> cnt=0, ovf=0, busy=1.
4. Priority, MAX_VAL=9: load=1, en=1, start=1, load_val=200 in one cycle -> cnt=9, tc=0, ovf=0, state unchanged.
5. ONESHOT RUN at cnt=5, en=1, rst=1 for one cycle -> next cycle cnt=RST_VAL, tc=0, ovf=0, busy=0 (IDLE).
6. WIDTH=8, WRAP, 2000 cycles of random en/dir/step/load -> cnt, tc, ovf match the bench reference model every cycle.

Source files
------------

// File: rtl/counter_ud_mode_pkg.sv
// Shared types for the up/down counter: overflow modes and one-shot FSM states.
// No logic here; reset-state helper keeps the mode-to-state mapping in one place.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2
  } cnt_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  // Free-running modes never leave RUN; one-shot waits for an explicit start.
  function automatic cnt_state_t reset_state(input cnt_mode_t mode);
    return (mode == CNT_ONESHOT) ? IDLE : RUN;
  endfunction

endpackage

// File: rtl/counter_ud_mode_if.sv
// Control/status bundle of the up/down counter; master drives controls, slave is the counter.
// No flow control: controls are sampled every clock, status is valid every clock.
interface counter_ud_mode_if #(
  parameter int WIDTH = 8
) ();

  logic             en;
  logic             dir;
  logic [WIDTH-1:0] step;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             ovf;
  logic             busy;

  modport master (
    output en, dir, step, load, load_val, start,
    input  cnt, tc, ovf, busy
  );

  modport slave (
    input  en, dir, step, load, load_val, start,
    output cnt, tc, ovf, busy
  );

endinterface

// File: rtl/counter_ud_mode_next_calc.sv
// Combinational next-count for one enabled step: range check, wrap or clamp, boundary hit.
// Zero latency; no state.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter cnt_mode_t        MODE    = CNT_WRAP
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] eff_step,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt,
  output logic             out_of_range,
  output logic             hit_boundary
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH:0]   up_raw;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;

  // Wrapped results always land in 0..MAX_VAL, so modulo-2**WIDTH arithmetic is exact.
  always_comb begin
    up_raw  = {1'b0, cnt} + {1'b0, eff_step};
    wrap_up = cnt + eff_step - MAX_VAL - ONE_W;
    wrap_dn = cnt - eff_step + MAX_VAL + ONE_W;
  end

  always_comb begin
    nxt          = cnt;
    out_of_range = 1'b0;
    hit_boundary = 1'b0;
    if (dir) begin
      out_of_range = (up_raw > {1'b0, MAX_VAL});
      if (!out_of_range)
        nxt = up_raw[WIDTH-1:0];
      else if (MODE == CNT_WRAP)
        nxt = wrap_up;
      else
        nxt = MAX_VAL;
    end else begin
      out_of_range = (eff_step > cnt);
      if (!out_of_range)
        nxt = cnt - eff_step;
      else if (MODE == CNT_WRAP)
        nxt = wrap_dn;
      else
        nxt = '0;
    end

    if (MODE == CNT_WRAP)
      hit_boundary = out_of_range;
    else if (dir)
      hit_boundary = (nxt == MAX_VAL) && (cnt != MAX_VAL);
    else
      hit_boundary = (nxt == '0) && (cnt != '0);
  end

endmodule

// File: rtl/counter_ud_mode.sv
// Parametrised up/down counter with load, wrap/saturate/one-shot modes, tc pulse and sticky ovf.
// All outputs registered; a sampled change appears on cnt one cycle later.
module counter_ud_mode
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RST_VAL = 64'd0,
  parameter cnt_mode_t       MODE    = CNT_WRAP
) (
  input logic                clk,
  input logic                rst,
  counter_ud_mode_if.slave   bus
);

  if (WIDTH < 1 || WIDTH > 63) begin : g_chk_width
    $fatal(1, "counter_ud_mode: WIDTH must be in 1..63");
  end
  if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_chk_max
    $fatal(1, "counter_ud_mode: MAX_VAL exceeds 2**WIDTH-1");
  end
  if (RST_VAL > MAX_VAL) begin : g_chk_rst
    $fatal(1, "counter_ud_mode: RST_VAL exceeds MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W     = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W     = RST_VAL[WIDTH-1:0];
  localparam bit               IS_ONESHOT = (MODE == CNT_ONESHOT);
  localparam cnt_state_t       RST_STATE = reset_state(MODE);

  cnt_state_t       state_q;
  cnt_state_t       state_d;
  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             ovf_q;
  logic             busy;

  logic [WIDTH-1:0] eff_step;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] nxt;
  logic             out_of_range;
  logic             hit_boundary;
  logic             do_start;
  logic             do_count;

  always_comb begin
    eff_step     = (bus.step > MAX_W) ? MAX_W : bus.step;
    load_clamped = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
    start_val    = bus.dir ? '0 : MAX_W;
    do_start     = IS_ONESHOT && bus.start;
    do_count     = bus.en && (state_q == RUN);
  end

  counter_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_W),
    .MODE    (MODE)
  ) u_next_calc (
    .cnt          (cnt_q),
    .eff_step     (eff_step),
    .dir          (bus.dir),
    .nxt          (nxt),
    .out_of_range (out_of_range),
    .hit_boundary (hit_boundary)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= RST_STATE;
    else
      state_q <= state_d;
  end

  // Load keeps the state; start (re)arms; a boundary hit finishes the one-shot run.
  always_comb begin
    state_d = state_q;
    if (!IS_ONESHOT)
      state_d = RUN;
    else if (bus.load)
      state_d = state_q;
    else if (do_start)
      state_d = RUN;
    else if (do_count && hit_boundary)
      state_d = DONE;
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_W;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.load) begin
      cnt_q <= load_clamped;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (do_start) begin
      cnt_q <= start_val;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (do_count) begin
      cnt_q <= nxt;
      tc_q  <= hit_boundary;
      ovf_q <= ovf_q | out_of_range;
    end else begin
      tc_q  <= 1'b0;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy;

endmodule
